// File: rtl/cskip_seq_ctrl_if.sv
// Requester handshake plus shared 4-bit carry-skip slice bus for cskip_seq_ctrl.
// slave = the sequencer; master = requester/slice side.
interface cskip_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH/4 + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic             sl_cin;
  logic [3:0]       sl_s;
  logic             sl_cout;
  logic             sl_bp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [CW-1:0]    skip_cnt;

  modport slave (
    input  in_valid, a, b, cin, sl_s, sl_cout, sl_bp, out_ready,
    output in_ready, sl_a, sl_b, sl_cin, out_valid, sum, cout, skip_cnt
  );

  modport master (
    output in_valid, a, b, cin, sl_s, sl_cout, sl_bp, out_ready,
    input  in_ready, sl_a, sl_b, sl_cin, out_valid, sum, cout, skip_cnt
  );
endinterface

// File: rtl/cskip_seq_ctrl.sv
// Nibble-serial adder: time-shares one external 4-bit carry-skip slice, LSB nibble
// first, and counts nibbles that took the skip path.
module cskip_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  cskip_seq_ctrl_if.slave  bus
);
  localparam int NIB = WIDTH/4;
  localparam int CW  = $clog2(NIB + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b, sum_r;
  logic             carry;
  logic [CW-1:0]    idx, skip_r;
  logic             in_ready_r, out_valid_r;
  logic [3:0]       sl_a_r, sl_b_r;
  logic             sl_cin_r;
  logic             last;

  assign last = (idx == CW'(NIB-1));

  // Operands shift right one nibble per step so the slice drive can be registered
  // one cycle ahead; op_x[3:0] is always the next nibble to present.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      sum_r       <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      skip_r      <= '0;
      sl_a_r      <= '0;
      sl_b_r      <= '0;
      sl_cin_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_a       <= bus.a >> 4;
          op_b       <= bus.b >> 4;
          carry      <= bus.cin;
          sl_a_r     <= bus.a[3:0];
          sl_b_r     <= bus.b[3:0];
          sl_cin_r   <= bus.cin;
          sum_r      <= '0;
          skip_r     <= '0;
          idx        <= '0;
          in_ready_r <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          sum_r[4*idx +: 4] <= bus.sl_s;
          carry             <= bus.sl_cout;
          skip_r            <= skip_r + CW'(bus.sl_bp);
          idx               <= idx + 1'b1;
          op_a              <= op_a >> 4;
          op_b              <= op_b >> 4;
          if (last) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            sl_a_r      <= '0;
            sl_b_r      <= '0;
            sl_cin_r    <= 1'b0;
          end else begin
            sl_a_r   <= op_a[3:0];
            sl_b_r   <= op_b[3:0];
            sl_cin_r <= bus.sl_cout;
          end
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sl_a      = sl_a_r;
  assign bus.sl_b      = sl_b_r;
  assign bus.sl_cin    = sl_cin_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = carry;
  assign bus.skip_cnt  = skip_r;
endmodule

// File: tb/tb_cskip_seq_ctrl.sv
// Self-checking bench for cskip_seq_ctrl: behavioural slice, directed cases and a
// randomized regression against plain-arithmetic expectations.
module tb_cskip_seq_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH/4;
  localparam int CW    = $clog2(NIB + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  cskip_seq_ctrl_if #(.WIDTH(WIDTH)) bus();
  cskip_seq_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign {bus.sl_cout, bus.sl_s} = 5'(bus.sl_a) + 5'(bus.sl_b) + 5'(bus.sl_cin);
  assign bus.sl_bp = &(bus.sl_a ^ bus.sl_b);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, y, input logic c);
    return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
  endfunction

  function automatic int ref_skip(input logic [WIDTH-1:0] x, y);
    logic [WIDTH-1:0] p;
    int n;
    p = x ^ y;
    n = 0;
    for (int i = 0; i < NIB; i++) if (p[4*i +: 4] == 4'hF) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; cins collects sl_cin as presented for each nibble.
  task automatic run_op(input logic [WIDTH-1:0] ia, ib, input logic ic, input int stall,
                        input bit hold_chk, input string tag, output logic [NIB-1:0] cins);
    int lat, k;
    logic [WIDTH:0] exp;
    exp  = ref_add(ia, ib, ic);
    cins = '0;
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a = ia; bus.b = ib; bus.cin = ic; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1; k = 0;
    while (!bus.out_valid && lat < 50) begin
      if (k < NIB) cins[k] = bus.sl_cin;
      k++;
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(NIB+1));
    chk({tag, " sum"}, 32'({bus.cout, bus.sum}), 32'(exp));
    chk({tag, " skip"}, 32'(bus.skip_cnt), 32'(ref_skip(ia, ib)));
    if (hold_chk) chk({tag, " idle drive"}, 32'({bus.sl_a, bus.sl_b, bus.sl_cin}), 32'd0);
    for (int i = 0; i < stall; i++) begin
      if (hold_chk && i == 3) begin
        bus.a = ~ia; bus.b = ~ib; bus.in_valid = 1'b1;
      end
      tick();
      bus.in_valid = 1'b0;
      if (hold_chk) begin
        chk({tag, " hold valid"}, 32'({bus.out_valid, bus.in_ready}), 32'b10);
        chk({tag, " hold sum"}, 32'({bus.cout, bus.sum}), 32'(exp));
        chk({tag, " hold skip"}, 32'(bus.skip_cnt), 32'(ref_skip(ia, ib)));
      end
    end
    if (stall > 0) chk({tag, " post-stall sum"}, 32'({bus.cout, bus.sum}), 32'(exp));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, " release"}, 32'({bus.in_ready, bus.out_valid}), 32'b10);
  endtask

  initial begin
    logic [NIB-1:0] cins;
    logic [WIDTH-1:0] ra, rb;
    logic rc;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;

    repeat (3) tick();
    chk("reset ready/valid", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    chk("reset sum/cout", 32'({bus.cout, bus.sum}), 32'd0);
    chk("reset skip", 32'(bus.skip_cnt), 32'd0);
    chk("reset slice drive", 32'({bus.sl_a, bus.sl_b, bus.sl_cin}), 32'd0);
    rst = 1'b0;
    tick();

    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, "mix", cins);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "ripple", cins);
    chk("ripple sl_cin", 32'(cins), 32'(4'b1110));
    run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0, "propagate", cins);
    chk("propagate sl_cin", 32'(cins), 32'(4'b1111));
    run_op(16'hA5C3, 16'h5A3C, 1'b0, 10, 1'b1, "backpressure", cins);

    // Abort in the second RUN cycle.
    bus.a = 16'hBEEF; bus.b = 16'h1111; bus.cin = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort ready/valid", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    chk("abort sum", 32'({bus.cout, bus.sum}), 32'd0);
    chk("abort skip", 32'(bus.skip_cnt), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, "after abort", cins);
    chk("after abort literal", 32'({bus.cout, bus.sum}), 32'h00100);

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ~ra ^ 16'($urandom_range(0, 15)) : 16'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'b0, "rand", cins);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
